// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, constants and bit-timing helper
//
// Contents:
//   tx_state_t      transmitter FSM state encoding (logic [2:0])
//   UART_DATA_BITS  data bits per frame
//   cycles_per_bit  clock cycles per line bit, shared with the receiver
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } tx_state_t;

    localparam int UART_DATA_BITS = 8;

    // Truncating division: the small baud error this introduces is absorbed
    // by the receiver's mid-bit sampling.
    function automatic int cycles_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous FIFO buffering bytes ahead of the transmitter
//
// Ports:
//   clk_in     main clock
//   reset_in   asynchronous active-low reset; empties the FIFO
//   push_in    write data_in (ignored when full)
//   data_in    write data
//   pop_in     drop the head entry (ignored when empty)
//   data_out   head entry, valid while !empty_out
//   full_out   DEPTH entries stored
//   empty_out  no entries stored
//   count_out  number of entries stored
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    input  logic                     push_in,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     pop_in,
    output logic [WIDTH-1:0]         data_out,
    output logic                     full_out,
    output logic                     empty_out,
    output logic [$clog2(DEPTH):0]   count_out
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit: equal low bits with differing MSBs means full.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign full_out  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_out = (wr_ptr_q == rd_ptr_q);
    assign count_out = wr_ptr_q - rd_ptr_q;
    assign data_out  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        push_ok  = push_in && !full_out;
        pop_ok   = pop_in && !empty_out;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_in;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: byte FIFO plus 8N1 bit-timing FSM
//
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit, 8E1).
//
// Ports:
//   clk_in        main clock
//   reset_in      asynchronous active-low reset
//   tx_data_in    byte to send
//   tx_valid_in   tx_data_in is valid this cycle
//   tx_ready_out  FIFO can accept a byte
//   tx_busy_out   FIFO non-empty or frame in progress (registered)
//   uart_tx_out   serial line, idles high (registered)
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 25000000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic [7:0] tx_data_in,
    input  logic       tx_valid_in,
    output logic       tx_ready_out,
    output logic       tx_busy_out,
    output logic       uart_tx_out
);

    localparam int CPB   = cycles_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);

    tx_state_t                     state_q, state_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [2:0]                    bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0]     shift_q, shift_d;
    logic                          tx_q, tx_d;
    logic                          busy_q, busy_d;

    logic                          fifo_push;
    logic                          fifo_pop;
    logic [UART_DATA_BITS-1:0]     fifo_dout;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic [AW:0]                   fifo_count;
    logic [AW:0]                   count_next;
    logic                          bit_end;

    assign fifo_push = tx_valid_in && !fifo_full;

    uart_tx_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in    (clk_in),
        .reset_in  (reset_in),
        .push_in   (fifo_push),
        .data_in   (tx_data_in),
        .pop_in    (fifo_pop),
        .data_out  (fifo_dout),
        .full_out  (fifo_full),
        .empty_out (fifo_empty),
        .count_out (fifo_count)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        fifo_pop  = 1'b0;
        bit_end   = (cnt_q == CNT_W'(CPB - 1));

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    tx_d     = 1'b0;
                    cnt_d    = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                    state_d   = DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = ^shift_q;
                        state_d = PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[bit_idx_q + 3'd1];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    // Chain straight into the next start bit so queued bytes
                    // go out back-to-back with no idle cycle.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        tx_d     = 1'b0;
                        state_d  = START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // Busy is registered, so it looks ahead at the post-edge occupancy.
        count_next = fifo_count + (AW+1)'(fifo_push) - (AW+1)'(fifo_pop);
        busy_d     = (state_d != IDLE) || (count_next != '0);
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign tx_ready_out = !fifo_full;
    assign tx_busy_out  = busy_q;
    assign uart_tx_out  = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard testbench for uart_tx with a frame-decoding monitor
module tb_uart_tx;

    localparam int CPB = 25000000 / 115200;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx_busy;
    logic       line;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    int         start_q[$];
    int         frames_seen = 0;
    logic       in_frame = 1'b0;

    uart_tx dut (
        .clk_in       (clk),
        .reset_in     (rst_n),
        .tx_data_in   (tx_data),
        .tx_valid_in  (tx_valid),
        .tx_ready_out (tx_ready),
        .tx_busy_out  (tx_busy),
        .uart_tx_out  (line)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: decode the line as a receiver would and compare each frame
    // against the oldest byte the scoreboard says was accepted.
    initial begin
        int             pos;
        int             k;
        logic           has_exp;
        logic           frame_bad;
        logic [7:0]     cur;
        logic [NBITS-1:0] exp_bits;
        logic [NBITS-1:0] got_bits;
        pos = 0; has_exp = 0; frame_bad = 0; cur = 0; exp_bits = '0; got_bits = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_frame = 1'b0;
            end else begin
                if (!in_frame) begin
                    if (line == 1'b0) begin
                        in_frame  = 1'b1;
                        pos       = 0;
                        frame_bad = 1'b0;
                        got_bits  = '0;
                        start_q.push_back(cyc);
                        has_exp = (exp_q.size() != 0);
                        cur     = has_exp ? exp_q.pop_front() : 8'h00;
                        exp_bits = '0;
                        for (int i = 0; i < 8; i++) exp_bits[i+1] = cur[i];
`ifdef UART_TX_PARITY_EN
                        exp_bits[9] = ^cur;
`endif
                        exp_bits[NBITS-1] = 1'b1;
                    end
                end else begin
                    pos++;
                end
                if (in_frame) begin
                    k = pos / CPB;
                    if (line !== exp_bits[k]) frame_bad = 1'b1;
                    if (pos % CPB == CPB / 2) got_bits[k] = line;
                    if (pos == FRAME - 1) begin
                        in_frame = 1'b0;
                        frames_seen++;
                        checks++;
                        if (!has_exp || frame_bad) begin
                            errors++;
                            $display("FAIL frame expected_present=%0d line_bits actual=%b required=%b",
                                     has_exp, got_bits, exp_bits);
                        end
                    end
                end
            end
        end
    end

    // Holds valid/data until accepted; records the byte on acceptance.
    task automatic push_byte(input logic [7:0] b, output int acc_cyc);
        logic acc;
        logic done;
        done = 1'b0;
        acc_cyc = -1;
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        for (int n = 0; n < 4 * FRAME && !done; n++) begin
            acc = tx_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                exp_q.push_back(b);
                acc_cyc = cyc;
                done = 1'b1;
            end
        end
        tx_valid = 1'b0;
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL push_timeout actual=not_accepted required=accepted");
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(negedge clk);
            if (!tx_busy && !in_frame && exp_q.size() == 0) ok = 1'b1;
        end
        check(name, ok, 1);
    endtask

    initial begin
        int pc;
        int n0;
        int f0;
        int fall;
        int bad;
        logic got;

        repeat (3) @(negedge clk);
        check("reset_line", line, 1);
        check("reset_ready", tx_ready, 1);
        check("reset_busy", tx_busy, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single byte: latency, frame contents (monitor) and busy duration.
        n0 = start_q.size();
        push_byte(8'h55, pc);
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            if (start_q.size() > n0) got = 1'b1;
        end
        check("single_start_seen", got, 1);
        if (got) check("single_latency", start_q[n0] - pc, 1);
        fall = -1;
        for (int n = 0; n < 2 * FRAME && fall < 0; n++) begin
            @(negedge clk);
            if (!tx_busy) fall = cyc;
        end
        if (got) check("single_busy_len", fall - start_q[n0], FRAME);
        wait_idle("single_idle", 2 * FRAME);

`ifdef UART_TX_PARITY_EN
        push_byte(8'h07, pc);
        wait_idle("parity_idle", 2 * FRAME);
`endif

        // Back-to-back frames.
        n0 = start_q.size();
        push_byte(8'hA3, pc);
        push_byte(8'h0F, pc);
        wait_idle("b2b_idle", 3 * FRAME);
        check("b2b_frames", start_q.size() - n0, 2);
        if (start_q.size() - n0 == 2) check("b2b_gap", start_q[n0+1] - start_q[n0], FRAME);

        // Fill the FIFO while the first frame is on the line.
        f0 = frames_seen;
        for (int i = 1; i <= 5; i++) push_byte(i[7:0], pc);
        check("full_ready_low", tx_ready, 0);
        push_byte(8'h06, pc);
        wait_idle("full_idle", 8 * FRAME);
        check("full_frames", frames_seen - f0, 6);

        // Reset during data bit 3 of 0xFF with two bytes queued.
        f0 = frames_seen;
        push_byte(8'hFF, pc);
        push_byte(8'h11, pc);
        push_byte(8'h22, pc);
        repeat (4 * CPB + CPB / 2 - 2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("rst_line_async", line, 1);
        check("rst_busy_async", tx_busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy_after", tx_busy, 0);
        check("rst_ready_after", tx_ready, 1);
        bad = 0;
        repeat (3 * FRAME) begin
            @(negedge clk);
            if (tx_busy || !line || in_frame) bad++;
        end
        check("rst_quiet_cycles_bad", bad, 0);
        check("rst_no_frames", frames_seen - f0, 0);

        // Reset during a start bit: the line must rise without a clock edge.
        push_byte(8'h00, pc);
        repeat (CPB / 2) @(negedge clk);
        check("start_bit_low", line, 0);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("rst_start_line_async", line, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Idle hold with data toggling but valid low.
        bad = 0;
        repeat (5000) begin
            @(negedge clk);
            tx_data = 8'($urandom);
            if (!line || tx_busy) bad++;
        end
        check("idle_hold_bad", bad, 0);

        // Random bytes with random gaps, sometimes overlapping frames.
        f0 = frames_seen;
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 300)) @(negedge clk);
            push_byte(8'($urandom), pc);
        end
        wait_idle("rand_idle", 10 * FRAME);
        check("rand_frames", frames_seen - f0, 6);
        check("final_line", line, 1);
        check("final_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
